// File: rtl/stimulus_gen_pkg.sv
// Shared definitions for the stimulus generator: mode codes, FSM state
// encoding and the maximal-length LFSR tap table.
package stimulus_gen_pkg;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_GRAY  = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Tap mask (bit i set = state bit i feeds the XOR) for a left-shifting
  // Fibonacci LFSR with the feedback entering bit 0.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    taps = 16'h0000;
    case (width)
      2:       taps = 16'h0003;
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/stimulus_gen_if.sv
// Control/vector bundle between a bench (master) and the generator (slave).
interface stimulus_gen_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [1:0]       mode;
  logic             pause;
  logic [WIDTH-1:0] vec;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (output start, mode, pause, input vec, valid, busy, done);
  modport slave  (input start, mode, pause, output vec, valid, busy, done);
endinterface

// File: rtl/stimulus_gen_lfsr.sv
// Maximal-length Fibonacci LFSR: shifts left, XOR of the tapped bits enters bit 0.
module stimulus_gen_lfsr
  import stimulus_gen_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);

  localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed;
    end else if (en) begin
      q <= {q[WIDTH-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/stimulus_gen.sv
// Clocked pattern generator: binary count, Gray, LFSR or walking-one vectors,
// each held for HOLD_CYC unpaused cycles, with a start/busy/done handshake.
module stimulus_gen
  import stimulus_gen_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int HOLD_CYC  = 10,
  parameter int LFSR_SEED = 1
) (
  input  logic           clk,
  input  logic           rst,
  stimulus_gen_if.slave  bus
);

  localparam int IDX_W  = WIDTH + 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [31:0]       SEED_FULL = LFSR_SEED;
  localparam logic [WIDTH-1:0]  SEED      = SEED_FULL[WIDTH-1:0];
  localparam logic [15:0]       TAPS_ALL  = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0]  TAPS      = TAPS_ALL[WIDTH-1:0];
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0]  CNT_LAST  = IDX_W'((1 << WIDTH) - 1);
  localparam logic [IDX_W-1:0]  WALK_LAST = IDX_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [1:0]         mode_q;
  logic [IDX_W-1:0]   idx;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WIDTH-1:0]   lfsr_q;
  logic [WIDTH-1:0]   lfsr_succ;
  logic [WIDTH-1:0]   cur_vec;
  logic               hold_end;
  logic               last_vec;
  logic               accept;
  logic               advance;

  stimulus_gen_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (advance),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Successor of the current LFSR value; the run ends on the vector whose
  // successor would wrap back to the seed.
  assign lfsr_succ = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign hold_end  = (hold_cnt == HOLD_LAST) && !bus.pause;

  always_comb begin
    cur_vec  = '0;
    last_vec = 1'b0;
    case (mode_q)
      MODE_COUNT: begin
        cur_vec  = idx[WIDTH-1:0];
        last_vec = (idx == CNT_LAST);
      end
      MODE_GRAY: begin
        cur_vec  = idx[WIDTH-1:0] ^ (idx[WIDTH-1:0] >> 1);
        last_vec = (idx == CNT_LAST);
      end
      MODE_LFSR: begin
        cur_vec  = lfsr_q;
        last_vec = (lfsr_succ == SEED);
      end
      default: begin
        cur_vec  = WIDTH'(1) << idx;
        last_vec = (idx == WALK_LAST);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    bus.vec   = '0;
    bus.valid = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        bus.vec   = cur_vec;
        bus.valid = 1'b1;
        bus.busy  = 1'b1;
        if (hold_end) begin
          if (last_vec) begin
            state_nxt = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode is captured only on an accepted start, so later mode changes are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_COUNT;
      idx      <= '0;
      hold_cnt <= '0;
    end else if (accept) begin
      mode_q   <= bus.mode;
      idx      <= '0;
      hold_cnt <= '0;
    end else if (state == RUN && !bus.pause) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= '0;
        if (advance) begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end else if (state == DONE) begin
      idx      <= '0;
      hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_stimulus_gen.sv
// Bench for stimulus_gen: two instances (HOLD_CYC=2 and 1) share stimulus and
// are each compared every cycle against an elapsed-time reference model.
module tb_stimulus_gen;
  import stimulus_gen_pkg::*;

  localparam int W    = 3;
  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stimulus_gen_if #(.WIDTH(W)) bus_a ();
  stimulus_gen_if #(.WIDTH(W)) bus_b ();

  stimulus_gen #(.WIDTH(W), .HOLD_CYC(2), .LFSR_SEED(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  stimulus_gen #(.WIDTH(W), .HOLD_CYC(1), .LFSR_SEED(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [1:0] mode;
    logic       pause;
    logic [5:0] exp;   // {vec, valid, busy, done}
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         lfsr_ref [7] = '{1, 2, 5, 3, 7, 6, 4};
  logic [2:0] gray_ref [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  // Reference model: 0 idle, 1 running, 2 done cycle; elapsed counts unpaused
  // run cycles since the start was accepted.
  int m_state   [NDUT];
  int m_elapsed [NDUT];
  int m_mode    [NDUT];

  function automatic int hold_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int seq_len(int md);
    case (md)
      0, 1:    return 8;
      2:       return 7;
      default: return W;
    endcase
  endfunction

  function automatic int exp_vec(int md, int i);
    case (md)
      0:       return i;
      1:       return i ^ (i >> 1);
      2:       return lfsr_ref[i];
      default: return 1 << i;
    endcase
  endfunction

  function automatic logic [5:0] exp_out(int d);
    case (m_state[d])
      1:       return {3'(exp_vec(m_mode[d], m_elapsed[d] / hold_of(d))), 3'b110};
      2:       return 6'b000_001;
      default: return 6'b000_000;
    endcase
  endfunction

  function automatic logic [5:0] act_out(int d);
    if (d == 0) return {bus_a.vec, bus_a.valid, bus_a.busy, bus_a.done};
    return {bus_b.vec, bus_b.valid, bus_b.busy, bus_b.done};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(logic st, logic [1:0] md, logic ps);
    bus_a.start = st;  bus_b.start = st;
    bus_a.mode  = md;  bus_b.mode  = md;
    bus_a.pause = ps;  bus_b.pause = ps;
  endtask

  task automatic model_edge(int d);
    if (rst) begin
      m_state[d] = 0;
    end else begin
      case (m_state[d])
        0: if (bus_a.start) begin
             m_state[d]   = 1;
             m_elapsed[d] = 0;
             m_mode[d]    = int'(bus_a.mode);
           end
        1: if (!bus_a.pause) begin
             m_elapsed[d]++;
             if (m_elapsed[d] == seq_len(m_mode[d]) * hold_of(d)) m_state[d] = 2;
           end
        default: m_state[d] = 0;
      endcase
    end
  endtask

  // One clock: advance the model on the edge, then compare both instances.
  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) model_edge(d);
    #1;
    check("model_a", act_out(0), exp_out(0));
    check("model_b", act_out(1), exp_out(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    set_in(1'b0, MODE_COUNT, 1'b0);
    while (!(m_state[0] == 0 && m_state[1] == 0) && n < 200) begin
      cycle();
      n++;
    end
    check("wait_idle_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int   valid_n;
    int   zero_seen;
    int   done_seen;

    // Walking-one, HOLD_CYC=2, pause held for three edges in the vec=2 phase.
    tbl[0]  = '{1'b1, 2'd3, 1'b0, 6'b001_110};
    tbl[1]  = '{1'b0, 2'd3, 1'b0, 6'b001_110};
    tbl[2]  = '{1'b0, 2'd3, 1'b0, 6'b010_110};
    tbl[3]  = '{1'b0, 2'd3, 1'b1, 6'b010_110};
    tbl[4]  = '{1'b0, 2'd3, 1'b1, 6'b010_110};
    tbl[5]  = '{1'b0, 2'd3, 1'b1, 6'b010_110};
    tbl[6]  = '{1'b0, 2'd3, 1'b0, 6'b010_110};
    tbl[7]  = '{1'b0, 2'd3, 1'b0, 6'b100_110};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 6'b100_110};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 6'b000_001};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 6'b000_000};

    for (int d = 0; d < NDUT; d++) begin
      m_state[d] = 0; m_elapsed[d] = 0; m_mode[d] = 0;
    end

    // Reset state
    set_in(1'b1, MODE_GRAY, 1'b0);
    rst = 1'b1;
    cycle();
    cycle();
    check("reset_a", act_out(0), 6'd0);
    check("reset_b", act_out(1), 6'd0);
    rst = 1'b0;
    set_in(1'b0, MODE_COUNT, 1'b0);
    cycle();

    // Binary count on dut_a: 0,0,1,1..7,7 then one done cycle, then idle
    for (int i = 0; i < 16; i++) begin
      set_in(i == 0, MODE_COUNT, 1'b0);
      cycle();
      check("count_vec", act_out(0), {3'(i / 2), 3'b110});
    end
    cycle();
    check("count_done", act_out(0), 6'b000_001);
    cycle();
    check("count_idle", act_out(0), 6'b000_000);

    // Gray on dut_b (HOLD_CYC=1)
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      set_in(i == 0, MODE_GRAY, 1'b0);
      cycle();
      check("gray_vec", act_out(1), {gray_ref[i], 3'b110});
    end
    cycle();
    check("gray_done", act_out(1), 6'b000_001);

    // LFSR on dut_b: seven vectors, never zero
    wait_idle();
    valid_n   = 0;
    zero_seen = 0;
    for (int i = 0; i < 9; i++) begin
      set_in(i == 0, MODE_LFSR, 1'b0);
      cycle();
      if (bus_b.valid) begin
        valid_n++;
        if (bus_b.vec == '0) zero_seen++;
      end
      if (i < 7) check("lfsr_vec", act_out(1), {3'(lfsr_ref[i]), 3'b110});
      if (i == 7) check("lfsr_done", act_out(1), 6'b000_001);
    end
    check("lfsr_valid_cycles", 32'(valid_n), 32'd7);
    check("lfsr_zero_emitted", 32'(zero_seen), 32'd0);

    // Walking-one with pause, table-driven on dut_a
    wait_idle();
    for (int r = 0; r < 11; r++) begin
      set_in(tbl[r].start, tbl[r].mode, tbl[r].pause);
      cycle();
      check("walk_pause_tbl", act_out(0), tbl[r].exp);
    end

    // Gray on dut_a with stray starts and mode changes mid-run
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      if (i == 0) set_in(1'b1, MODE_GRAY, 1'b0);
      else        set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
      cycle();
      check("midrun_gray_vec", act_out(0), {3'((i / 2) ^ (i / 4)), 3'b110});
    end
    set_in(1'b1, MODE_WALK, 1'b0);
    cycle();
    check("midrun_done", act_out(0), 6'b000_001);
    set_in(1'b1, MODE_COUNT, 1'b0);
    cycle();
    check("start_in_done_ignored", act_out(0), 6'b000_000);
    cycle();
    check("restart_from_zero", act_out(0), 6'b000_110);

    // rst in the middle of a count run on dut_a, at vec=5
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, MODE_COUNT, 1'b0);
      cycle();
    end
    check("pre_reset_vec", act_out(0), 6'b101_110);
    rst = 1'b1;
    cycle();
    check("reset_midrun", act_out(0), 6'b000_000);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus_a.done) done_seen++;
    end
    check("no_done_after_reset", 32'(done_seen), 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      cycle();
    end
    rst = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
